xbar_route_builder: RTL and testbench
=====================================

// Module: xbar_route_builder
// PURPOSE
// Builds the 512-bit crossbar routing map from single-connection commands on the EBI command bus, then pushes it to the
// xbar serialiser as 16 word writes plus a command write and polls its BUSY register until the load finishes. It is the
// stage directly upstream of the xbar serialiser: bus slave to the MCU, bus master to the serialiser.
// PARAMETERS
// POSITION   1      own address page (cmd_bus_addr[15:8])
// XBAR_POS   0      serialiser address page used on the master side
// TIMEOUT    4095   max ebi_clk cycles per poll phase before abort (16-bit counter)
// PORTS
// ebi_clk         in   1   system clock; everything sampled on rising edge
// reset           in   1   synchronous, active-high
// cmd_bus_enable  in   1   bus cycle valid
// cmd_bus_wr      in   1   write strobe
// re              in   1   read strobe
// cmd_bus_addr    in   16  [15:8] page, [7:0] register
// cmd_bus_data    in   32  write data
// data_out        out  16  registered read data; 0 when not read
// xb_enable       out  1   master: bus cycle valid to serialiser
// xb_wr           out  1   master: write strobe
// xb_re           out  1   master: read strobe
// xb_addr         out  16  master: {XBAR_POS, reg}
// xb_data         out  32  master: write data
// xb_rdata        in   16  serialiser data_out (one-cycle read latency)
// BEHAVIOUR
// - cs = cmd_bus_enable & addr[15:8]==POSITION. Map = 16 words x 32 bits, word y bit x = switch (x,y).
// - Regs: 0x00 ROUTE wr: x=data[4:0], y=data[11:8], data[16]=1 set / 0 clear bit. 0x01 CLEAR wr: all bits 0 in 1 cycle.
//   0x02 COMMIT wr: start push. 0x08 STATUS rd: {12'b0,err_timeout,err_drop,dirty,busy}. 0x09 ID rd: 16'h7b10.
//   0x0A COMMITS rd: 16-bit successful-push count, wraps 0xFFFF->0. Unmapped reads return 0.
// - data_out valid cycle after cs&re; 0 otherwise. Reading STATUS clears err_drop and err_timeout after the read.
// - Reset: map 0, all outputs 0, flags 0, COMMITS 0, FSM IDLE. Reset mid-push aborts; no further master cycles.
// - FSM: IDLE -> (COMMIT) WORDS -> CMD -> POLL_HI -> POLL_LO -> IDLE.
//   WORDS: 16 cycles, word i written to xb_addr {XBAR_POS,4'h0,i[3:0]}, i=0..15; dirty cleared on entry.
//   CMD: one write to {XBAR_POS,8'h20}, xb_data=1.
//   POLL_HI: xb_re held, xb_addr {XBAR_POS,8'h0A}; leave when xb_rdata[0]==1 (load accepted).
//   POLL_LO: same read; leave when xb_rdata[0]==0; COMMITS++ on exit.
//   Poll sampling ignores the first cycle after each read address change (latency). Either poll phase exceeding
//   TIMEOUT cycles -> err_timeout=1, IDLE, COMMITS unchanged.
// - Latency: COMMIT write at cycle N -> words N+1..N+16, CMD at N+17, first poll read N+18.
// - busy = FSM!=IDLE. ROUTE/CLEAR/COMMIT while busy: dropped, map unchanged, err_drop=1.
// - Same-cycle COMMIT and any other write impossible (one bus cycle); ROUTE accepted in IDLE sets dirty.
// - Master outputs registered; xb_enable/xb_wr/xb_re low outside their states.
// CONFIGURATION
// XBAR_SHADOW_READ_EN defined: reads at 0x40+2w / 0x41+2w return low / high half of map word w (w=0..15).
// Undefined: those addresses read 0; no read mux in the map.
// TESTING
// - Reset then read ID/STATUS/COMMITS -> 16'h7b10, 0, 0; all xb_* outputs 0.
// - ROUTE 0x0001_0305 then COMMIT; serialiser model -> word 3 write data 32'h0000_0020, others 0, then 0x20 <- 1.
// - Model BUSY 0,1x10,0 -> FSM idle after POLL_LO, COMMITS=1, STATUS=0 (dirty cleared).
// - Model BUSY stuck 0 with TIMEOUT=15 -> abort after 15 poll cycles, STATUS=0x0008, COMMITS=0.
// - ROUTE during push -> map unchanged, STATUS=0x0005, next STATUS read 0x0001.
// - Assert reset at word 7 of push -> xb_enable 0 next cycle, map all 0, with macro shadow reads 0.

Source files
------------

// File: rtl/xbar_route_builder.sv
// Crossbar route builder: collects single-switch commands into a 16x32 map and pushes it to the xbar serialiser.
// Optional build macro XBAR_SHADOW_READ_EN exposes the map as read-only shadow registers at 0x40..0x5F.
module xbar_route_builder #(
    parameter logic [7:0]  POSITION = 8'd1,
    parameter logic [7:0]  XBAR_POS = 8'd0,
    parameter logic [15:0] TIMEOUT  = 16'd4095
) (
    input  logic        ebi_clk,
    input  logic        reset,
    input  logic        cmd_bus_enable,
    input  logic        cmd_bus_wr,
    input  logic        re,
    input  logic [15:0] cmd_bus_addr,
    input  logic [31:0] cmd_bus_data,
    output logic [15:0] data_out,
    output logic        xb_enable,
    output logic        xb_wr,
    output logic        xb_re,
    output logic [15:0] xb_addr,
    output logic [31:0] xb_data,
    input  logic [15:0] xb_rdata
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WORDS   = 3'd1;
    localparam logic [2:0] ST_CMD     = 3'd2;
    localparam logic [2:0] ST_POLL_HI = 3'd3;
    localparam logic [2:0] ST_POLL_LO = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic        skip_q, skip_d;
    logic [31:0] map_q [16];
    logic [31:0] map_d [16];
    logic        dirty_q, dirty_d;
    logic        err_drop_q, err_drop_d;
    logic        err_to_q, err_to_d;
    logic [15:0] commits_q, commits_d;
    logic [15:0] data_out_q, data_out_d;
    logic        xb_enable_q, xb_enable_d;
    logic        xb_wr_q, xb_wr_d;
    logic        xb_re_q, xb_re_d;
    logic [15:0] xb_addr_q, xb_addr_d;
    logic [31:0] xb_data_q, xb_data_d;

    logic        cs_s, wr_s, rd_s, busy_s;
    logic [7:0]  reg_s;
    logic [3:0]  idx_n_s;
    logic        unused_ok_s;

    assign cs_s    = cmd_bus_enable && (cmd_bus_addr[15:8] == POSITION);
    assign wr_s    = cs_s && cmd_bus_wr;
    assign rd_s    = cs_s && re;
    assign reg_s   = cmd_bus_addr[7:0];
    assign busy_s  = (state_q != ST_IDLE);
    assign idx_n_s = idx_q + 4'd1;
    assign unused_ok_s = ^{cmd_bus_data[31:17], cmd_bus_data[15:12], cmd_bus_data[7:5], xb_rdata[15:1]};

    assign data_out  = data_out_q;
    assign xb_enable = xb_enable_q;
    assign xb_wr     = xb_wr_q;
    assign xb_re     = xb_re_q;
    assign xb_addr   = xb_addr_q;
    assign xb_data   = xb_data_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        skip_d      = 1'b0;
        map_d       = map_q;
        dirty_d     = dirty_q;
        err_drop_d  = err_drop_q;
        err_to_d    = err_to_q;
        commits_d   = commits_q;
        data_out_d  = 16'h0000;
        xb_enable_d = 1'b0;
        xb_wr_d     = 1'b0;
        xb_re_d     = 1'b0;
        xb_addr_d   = 16'h0000;
        xb_data_d   = 32'h0000_0000;

        if (rd_s) begin
            case (reg_s)
                8'h08: begin
                    data_out_d = {12'h000, err_to_q, err_drop_q, dirty_q, busy_s};
                    err_drop_d = 1'b0;
                    err_to_d   = 1'b0;
                end
                8'h09: data_out_d = 16'h7b10;
                8'h0A: data_out_d = commits_q;
                default: begin
`ifdef XBAR_SHADOW_READ_EN
                    if (reg_s[7:5] == 3'b010) begin
                        data_out_d = reg_s[0] ? map_q[reg_s[4:1]][31:16] : map_q[reg_s[4:1]][15:0];
                    end else begin
                        data_out_d = 16'h0000;
                    end
`else
                    data_out_d = 16'h0000;
`endif
                end
            endcase
        end else begin
            data_out_d = 16'h0000;
        end

        // Map-changing commands are refused while a push is in flight so the pushed image stays coherent.
        if (wr_s && busy_s && (reg_s == 8'h00 || reg_s == 8'h01 || reg_s == 8'h02)) begin
            err_drop_d = 1'b1;
        end else if (wr_s) begin
            case (reg_s)
                8'h00: begin
                    map_d[cmd_bus_data[11:8]][cmd_bus_data[4:0]] = cmd_bus_data[16];
                    dirty_d = 1'b1;
                end
                8'h01: begin
                    for (int w = 0; w < 16; w++) begin
                        map_d[w] = 32'h0000_0000;
                    end
                end
                8'h02: begin
                    state_d     = ST_WORDS;
                    idx_d       = 4'd0;
                    dirty_d     = 1'b0;
                    xb_enable_d = 1'b1;
                    xb_wr_d     = 1'b1;
                    xb_addr_d   = {XBAR_POS, 8'h00};
                    xb_data_d   = map_q[0];
                end
                default: ;
            endcase
        end else begin
            dirty_d = dirty_q;
        end

        // State encodes what is on the master bus this cycle; the d-side sets up next cycle's transfer.
        case (state_q)
            ST_WORDS: begin
                xb_enable_d = 1'b1;
                xb_wr_d     = 1'b1;
                if (idx_q == 4'd15) begin
                    state_d   = ST_CMD;
                    xb_addr_d = {XBAR_POS, 8'h20};
                    xb_data_d = 32'h0000_0001;
                end else begin
                    idx_d     = idx_n_s;
                    xb_addr_d = {XBAR_POS, 4'h0, idx_n_s};
                    xb_data_d = map_q[idx_n_s];
                end
            end
            ST_CMD: begin
                state_d     = ST_POLL_HI;
                cnt_d       = 16'd0;
                skip_d      = 1'b1;
                xb_enable_d = 1'b1;
                xb_re_d     = 1'b1;
                xb_addr_d   = {XBAR_POS, 8'h0A};
            end
            ST_POLL_HI, ST_POLL_LO: begin
                xb_enable_d = 1'b1;
                xb_re_d     = 1'b1;
                xb_addr_d   = {XBAR_POS, 8'h0A};
                if (state_q == ST_POLL_HI && !skip_q && xb_rdata[0]) begin
                    state_d = ST_POLL_LO;
                    cnt_d   = 16'd0;
                end else if (state_q == ST_POLL_LO && !xb_rdata[0]) begin
                    state_d     = ST_IDLE;
                    commits_d   = commits_q + 16'd1;
                    xb_enable_d = 1'b0;
                    xb_re_d     = 1'b0;
                    xb_addr_d   = 16'h0000;
                end else if (cnt_q == TIMEOUT - 16'd1) begin
                    state_d     = ST_IDLE;
                    err_to_d    = 1'b1;
                    xb_enable_d = 1'b0;
                    xb_re_d     = 1'b0;
                    xb_addr_d   = 16'h0000;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: ;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge ebi_clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= 4'd0;
            cnt_q       <= 16'd0;
            skip_q      <= 1'b0;
            for (int w = 0; w < 16; w++) begin
                map_q[w] <= 32'h0000_0000;
            end
            dirty_q     <= 1'b0;
            err_drop_q  <= 1'b0;
            err_to_q    <= 1'b0;
            commits_q   <= 16'd0;
            data_out_q  <= 16'h0000;
            xb_enable_q <= 1'b0;
            xb_wr_q     <= 1'b0;
            xb_re_q     <= 1'b0;
            xb_addr_q   <= 16'h0000;
            xb_data_q   <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            skip_q      <= skip_d;
            for (int w = 0; w < 16; w++) begin
                map_q[w] <= map_d[w];
            end
            dirty_q     <= dirty_d;
            err_drop_q  <= err_drop_d;
            err_to_q    <= err_to_d;
            commits_q   <= commits_d;
            data_out_q  <= data_out_d;
            xb_enable_q <= xb_enable_d;
            xb_wr_q     <= xb_wr_d;
            xb_re_q     <= xb_re_d;
            xb_addr_q   <= xb_addr_d;
            xb_data_q   <= xb_data_d;
        end
    end

endmodule

// File: tb/tb_xbar_route_builder.sv
// Directed bench for xbar_route_builder with a small serialiser model answering BUSY polls.
`timescale 1ns/1ps
module tb_xbar_route_builder;

    logic        ebi_clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_bus_enable = 1'b0;
    logic        cmd_bus_wr = 1'b0;
    logic        re = 1'b0;
    logic [15:0] cmd_bus_addr = 16'h0000;
    logic [31:0] cmd_bus_data = 32'h0000_0000;
    logic [15:0] data_out;
    logic        xb_enable, xb_wr, xb_re;
    logic [15:0] xb_addr;
    logic [31:0] xb_data;
    logic [15:0] xb_rdata = 16'h0000;

    int checks = 0;
    int errors = 0;
    int mode = 0;
    int m_idx = 0;
    int rd_cnt = 0;
    logic [15:0] wa_q [$];
    logic [31:0] wd_q [$];

    xbar_route_builder #(.POSITION(8'd1), .XBAR_POS(8'd0), .TIMEOUT(16'd15)) dut (
        .ebi_clk(ebi_clk), .reset(reset), .cmd_bus_enable(cmd_bus_enable), .cmd_bus_wr(cmd_bus_wr),
        .re(re), .cmd_bus_addr(cmd_bus_addr), .cmd_bus_data(cmd_bus_data), .data_out(data_out),
        .xb_enable(xb_enable), .xb_wr(xb_wr), .xb_re(xb_re), .xb_addr(xb_addr), .xb_data(xb_data),
        .xb_rdata(xb_rdata)
    );

    always #5 ebi_clk = ~ebi_clk;

    // Serialiser model: BUSY pattern 0,1x10,0... (mode 0) or stuck at 0 (mode 1), one-cycle read latency.
    always @(posedge ebi_clk) begin
        if (xb_enable && xb_wr && xb_addr == 16'h0020) begin
            m_idx <= 0;
            xb_rdata <= 16'h0000;
        end else if (xb_enable && xb_re && xb_addr == 16'h000A) begin
            m_idx <= m_idx + 1;
            xb_rdata <= {15'h0000, (mode == 0 && m_idx >= 1 && m_idx <= 10)};
        end else begin
            xb_rdata <= 16'h0000;
        end
    end

    // Log master writes and count poll reads.
    always @(negedge ebi_clk) begin
        if (xb_enable && xb_wr) begin
            wa_q.push_back(xb_addr);
            wd_q.push_back(xb_data);
        end
        if (xb_enable && xb_re) rd_cnt <= rd_cnt + 1;
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge ebi_clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        cmd_bus_enable = 1'b1; cmd_bus_wr = 1'b1; cmd_bus_addr = a; cmd_bus_data = d;
        tick(1);
        cmd_bus_enable = 1'b0; cmd_bus_wr = 1'b0; cmd_bus_addr = 16'h0000; cmd_bus_data = 32'h0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        cmd_bus_enable = 1'b1; re = 1'b1; cmd_bus_addr = a;
        tick(1);
        d = data_out;
        cmd_bus_enable = 1'b0; re = 1'b0; cmd_bus_addr = 16'h0000;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        checks++;
        if ({xb_enable, xb_wr, xb_re, xb_addr, xb_data} !== 51'h0) begin
            errors++; $display("FAIL reset_xb got %h want 0", {xb_enable, xb_wr, xb_re, xb_addr, xb_data});
        end
        bus_read(16'h0109, d);
        checks++; if (d !== 16'h7b10) begin errors++; $display("FAIL id got %h want 7b10", d); end
        tick(1);
        checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL idle_data_out got %h want 0", data_out); end
        bus_read(16'h0108, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_status got %h want 0", d); end
        bus_read(16'h010A, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_commits got %h want 0", d); end
        bus_read(16'h0103, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL unmapped got %h want 0", d); end
        bus_read(16'h0209, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL other_page got %h want 0", d); end
    endtask

    task automatic test_timeout();
        logic [15:0] d;
        int base, r0;
        mode = 1;
        base = wa_q.size();
        r0 = rd_cnt;
        bus_write(16'h0102, 32'h0);
        tick(40);
        checks++; if (wa_q.size() - base !== 17) begin errors++; $display("FAIL to_writes got %0d want 17", wa_q.size() - base); end
        checks++; if (rd_cnt - r0 !== 15) begin errors++; $display("FAIL to_polls got %0d want 15", rd_cnt - r0); end
        bus_read(16'h0108, d);
        checks++; if (d !== 16'h0008) begin errors++; $display("FAIL to_status got %h want 0008", d); end
        bus_read(16'h010A, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL to_commits got %h want 0", d); end
        bus_read(16'h0108, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL to_status_clr got %h want 0", d); end
    endtask

    task automatic test_route_commit();
        logic [15:0] d;
        int base, r0;
        mode = 0;
        bus_write(16'h0100, 32'h0001_0305);
        bus_read(16'h0108, d);
        checks++; if (d !== 16'h0002) begin errors++; $display("FAIL dirty_status got %h want 0002", d); end
`ifdef XBAR_SHADOW_READ_EN
        bus_read(16'h0146, d);
        checks++; if (d !== 16'h0020) begin errors++; $display("FAIL shadow_lo got %h want 0020", d); end
        bus_read(16'h0147, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL shadow_hi got %h want 0", d); end
`endif
        base = wa_q.size();
        r0 = rd_cnt;
        bus_write(16'h0102, 32'h0);
        checks++;
        if (!(xb_enable && xb_wr && xb_addr == 16'h0000)) begin
            errors++; $display("FAIL word0_latency got en=%b wr=%b addr=%h want 1 1 0000", xb_enable, xb_wr, xb_addr);
        end
        tick(16);
        checks++;
        if (!(xb_enable && xb_wr && xb_addr == 16'h0020 && xb_data == 32'h1)) begin
            errors++; $display("FAIL cmd_latency got addr=%h data=%h want 0020 1", xb_addr, xb_data);
        end
        tick(1);
        checks++;
        if (!(xb_enable && xb_re && !xb_wr && xb_addr == 16'h000A)) begin
            errors++; $display("FAIL poll_latency got re=%b addr=%h want 1 000a", xb_re, xb_addr);
        end
        tick(30);
        checks++; if (wa_q.size() - base !== 17) begin errors++; $display("FAIL rc_writes got %0d want 17", wa_q.size() - base); end
        if (wa_q.size() - base >= 17) begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (wa_q[base+i] !== 16'(i) || wd_q[base+i] !== ((i == 3) ? 32'h0000_0020 : 32'h0)) begin
                    errors++; $display("FAIL word%0d got %h/%h want %h/%h", i, wa_q[base+i], wd_q[base+i], 16'(i), (i == 3) ? 32'h20 : 32'h0);
                end
            end
            checks++;
            if (wa_q[base+16] !== 16'h0020 || wd_q[base+16] !== 32'h1) begin
                errors++; $display("FAIL cmd_write got %h/%h want 0020/1", wa_q[base+16], wd_q[base+16]);
            end
        end
        checks++; if (rd_cnt - r0 !== 13) begin errors++; $display("FAIL rc_polls got %0d want 13", rd_cnt - r0); end
        bus_read(16'h010A, d);
        checks++; if (d !== 16'h0001) begin errors++; $display("FAIL rc_commits got %h want 1", d); end
        bus_read(16'h0108, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL rc_status got %h want 0", d); end
    endtask

    task automatic test_drop();
        logic [15:0] d;
        int base;
        mode = 0;
        bus_write(16'h0102, 32'h0);
        bus_write(16'h0100, 32'h0001_0001);
        bus_read(16'h0108, d);
        checks++; if (d !== 16'h0005) begin errors++; $display("FAIL drop_status got %h want 0005", d); end
        bus_read(16'h0108, d);
        checks++; if (d !== 16'h0001) begin errors++; $display("FAIL drop_status2 got %h want 0001", d); end
        tick(40);
        bus_read(16'h010A, d);
        checks++; if (d !== 16'h0002) begin errors++; $display("FAIL drop_commits got %h want 2", d); end
        base = wa_q.size();
        bus_write(16'h0102, 32'h0);
        tick(40);
        checks++;
        if (wa_q.size() - base !== 17 || wd_q[base] !== 32'h0 || wd_q[base+3] !== 32'h20) begin
            errors++; $display("FAIL drop_map got n=%0d w0=%h w3=%h want 17 0 20", wa_q.size() - base, wd_q[base], wd_q[base+3]);
        end
    endtask

    task automatic test_clear();
        logic [31:0] acc;
        int base;
        bus_write(16'h0100, 32'h0001_0F1F);
        bus_write(16'h0101, 32'h0);
        base = wa_q.size();
        bus_write(16'h0102, 32'h0);
        tick(40);
        acc = 32'h0;
        for (int i = 0; i < 16; i++) acc = acc | wd_q[base+i];
        checks++; if (acc !== 32'h0) begin errors++; $display("FAIL clear_map got %h want 0", acc); end
    endtask

    task automatic test_reset_mid_push();
        logic [15:0] d;
        int base, n0;
        bit found;
        bus_write(16'h0100, 32'h0001_0305);
        bus_write(16'h0102, 32'h0);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (xb_enable && xb_wr && xb_addr == 16'h0007) found = 1'b1;
            else tick(1);
        end
        checks++; if (!found) begin errors++; $display("FAIL word7_seen got 0 want 1"); end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checks++; if (xb_enable !== 1'b0) begin errors++; $display("FAIL rst_xb_enable got %b want 0", xb_enable); end
        n0 = wa_q.size();
        tick(5);
        checks++; if (wa_q.size() !== n0) begin errors++; $display("FAIL rst_quiet got %0d want %0d", wa_q.size(), n0); end
        bus_read(16'h010A, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL rst_commits got %h want 0", d); end
`ifdef XBAR_SHADOW_READ_EN
        bus_read(16'h0146, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL rst_shadow got %h want 0", d); end
`endif
        base = wa_q.size();
        bus_write(16'h0102, 32'h0);
        tick(40);
        checks++;
        if (wa_q.size() - base !== 17 || wd_q[base+3] !== 32'h0) begin
            errors++; $display("FAIL rst_map got n=%0d w3=%h want 17 0", wa_q.size() - base, wd_q[base+3]);
        end
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_route_commit();
        test_drop();
        test_clear();
        test_reset_mid_push();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
